// File: rtl/gat_bram_loader.sv
// gat_bram_loader: host-side writer for the five GAT input BRAMs.
// Parses one framed word stream into five length-prefixed sections
// (H_col_idx, H_value, H_node_info, Weight, a). It drives each BRAM's
// port-A write interface and raises that BRAM's sticky load_done flag.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_data/s_valid/s_last      input stream word, valid, end-of-frame marker
//   s_ready                    loader accepts words (HDR/DATA states)
//   <bram>_din/_ena/_addra     registered port-A write interface per BRAM
//   <bram>_load_done           sticky "section fully received" flag
//   busy_o                     frame in progress
//   err_o                      sticky framing/overflow error
module gat_bram_loader #(
  parameter int unsigned IN_W              = 32,
  parameter int unsigned COL_IDX_WIDTH     = 11,
  parameter int unsigned VALUE_WIDTH       = 8,
  parameter int unsigned NODE_INFO_WIDTH   = 15,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned COL_IDX_DEPTH     = 242,
  parameter int unsigned VALUE_DEPTH       = 242,
  parameter int unsigned NODE_INFO_DEPTH   = 13,
  parameter int unsigned WEIGHT_DEPTH      = 256,
  parameter int unsigned A_DEPTH           = 32,
  localparam int unsigned COL_IDX_ADDR_W   = $clog2(COL_IDX_DEPTH),
  localparam int unsigned VALUE_ADDR_W     = $clog2(VALUE_DEPTH),
  localparam int unsigned NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  localparam int unsigned WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH),
  localparam int unsigned A_ADDR_W         = $clog2(A_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_W-1:0]             s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic [COL_IDX_WIDTH-1:0]    H_col_idx_BRAM_din,
  output logic                        H_col_idx_BRAM_ena,
  output logic [COL_IDX_ADDR_W-1:0]   H_col_idx_BRAM_addra,
  output logic                        H_col_idx_BRAM_load_done,
  output logic [VALUE_WIDTH-1:0]      H_value_BRAM_din,
  output logic                        H_value_BRAM_ena,
  output logic [VALUE_ADDR_W-1:0]     H_value_BRAM_addra,
  output logic                        H_value_BRAM_load_done,
  output logic [NODE_INFO_WIDTH-1:0]  H_node_info_BRAM_din,
  output logic                        H_node_info_BRAM_ena,
  output logic [NODE_INFO_ADDR_W-1:0] H_node_info_BRAM_addra,
  output logic                        H_node_info_BRAM_load_done,
  output logic [DATA_WIDTH-1:0]       Weight_BRAM_din,
  output logic                        Weight_BRAM_ena,
  output logic [WEIGHT_ADDR_W-1:0]    Weight_BRAM_addra,
  output logic                        Weight_BRAM_load_done,
  output logic [DATA_WIDTH-1:0]       a_BRAM_din,
  output logic                        a_BRAM_ena,
  output logic [A_ADDR_W-1:0]         a_BRAM_addra,
  output logic                        a_BRAM_load_done,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned N_SEC = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1, ST_DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [2:0]           sec_q, sec_d;
  logic [CNT_W-1:0]     n_q, n_d, idx_q, idx_d;
  logic                 err_q, err_d, busy_q, busy_d;
  logic [N_SEC-1:0]     wr_q, wr_d, pend_q, pend_d, done_q, done_d;

  logic [COL_IDX_WIDTH-1:0]    col_din_q;
  logic [COL_IDX_ADDR_W-1:0]   col_addr_q;
  logic [VALUE_WIDTH-1:0]      val_din_q;
  logic [VALUE_ADDR_W-1:0]     val_addr_q;
  logic [NODE_INFO_WIDTH-1:0]  ni_din_q;
  logic [NODE_INFO_ADDR_W-1:0] ni_addr_q;
  logic [DATA_WIDTH-1:0]       w_din_q;
  logic [WEIGHT_ADDR_W-1:0]    w_addr_q;
  logic [DATA_WIDTH-1:0]       a_din_q;
  logic [A_ADDR_W-1:0]         a_addr_q;

  logic             accept_c, sec_end_c, last_sec_c;
  logic [N_SEC-1:0] sec_oh_c;
  logic [31:0]      depth_c;
  logic [CNT_W-1:0] hdr_n_c;
  logic             unused_c;

  // Header upper bits and data bits above each BRAM width are dropped by design.
  assign unused_c   = ^s_data;
  assign accept_c   = s_valid && (state_q != ST_DONE);
  assign hdr_n_c    = s_data[CNT_W-1:0];
  assign sec_oh_c   = N_SEC'(1) << sec_q;
  assign last_sec_c = (sec_q == 3'd4);

  // Depth of the section currently being loaded.
  always_comb begin
    case (sec_q)
      3'd0:    depth_c = 32'(COL_IDX_DEPTH);
      3'd1:    depth_c = 32'(VALUE_DEPTH);
      3'd2:    depth_c = 32'(NODE_INFO_DEPTH);
      3'd3:    depth_c = 32'(WEIGHT_DEPTH);
      default: depth_c = 32'(A_DEPTH);
    endcase
  end

  // Next-state and write-strobe logic.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    n_d       = n_q;
    idx_d     = idx_q;
    err_d     = err_q;
    busy_d    = busy_q;
    wr_d      = '0;
    pend_d    = '0;
    done_d    = done_q | pend_q;
    sec_end_c = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (accept_c) begin
          busy_d = 1'b1;
          n_d    = hdr_n_c;
          idx_d  = '0;
          if (hdr_n_c == '0) begin
            // Empty section completes on its header alone.
            done_d    = done_d | sec_oh_c;
            sec_end_c = 1'b1;
          end else begin
            state_d = ST_DATA;
            if ({16'd0, hdr_n_c} > depth_c) err_d = 1'b1;
            if (s_last) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          busy_d = 1'b1;
          // Overflow entries are consumed but not written.
          if ({16'd0, idx_q} < depth_c) wr_d = sec_oh_c;
          idx_d = idx_q + 16'd1;
          if (idx_q == n_q - 16'd1) begin
            // load_done follows the final write pulse by one cycle.
            pend_d    = sec_oh_c;
            sec_end_c = 1'b1;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: ;
    endcase

    if (sec_end_c) begin
      if (last_sec_c) begin
        state_d = ST_DONE;
        if (!s_last) err_d = 1'b1;
      end else begin
        sec_d   = sec_q + 3'd1;
        state_d = ST_HDR;
        if (s_last) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
    end

    if (state_d == ST_DONE) busy_d = 1'b0;
  end

  // State and write-port registers; din/addra only move on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      sec_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= '0;
      pend_q     <= '0;
      done_q     <= '0;
      col_din_q  <= '0;
      col_addr_q <= '0;
      val_din_q  <= '0;
      val_addr_q <= '0;
      ni_din_q   <= '0;
      ni_addr_q  <= '0;
      w_din_q    <= '0;
      w_addr_q   <= '0;
      a_din_q    <= '0;
      a_addr_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      if (wr_d[0]) begin
        col_din_q  <= COL_IDX_WIDTH'(s_data);
        col_addr_q <= COL_IDX_ADDR_W'(idx_q);
      end
      if (wr_d[1]) begin
        val_din_q  <= VALUE_WIDTH'(s_data);
        val_addr_q <= VALUE_ADDR_W'(idx_q);
      end
      if (wr_d[2]) begin
        ni_din_q  <= NODE_INFO_WIDTH'(s_data);
        ni_addr_q <= NODE_INFO_ADDR_W'(idx_q);
      end
      if (wr_d[3]) begin
        w_din_q  <= DATA_WIDTH'(s_data);
        w_addr_q <= WEIGHT_ADDR_W'(idx_q);
      end
      if (wr_d[4]) begin
        a_din_q  <= DATA_WIDTH'(s_data);
        a_addr_q <= A_ADDR_W'(idx_q);
      end
    end
  end

  assign s_ready = (state_q != ST_DONE);
  assign busy_o  = busy_q;
  assign err_o   = err_q;

  assign H_col_idx_BRAM_din         = col_din_q;
  assign H_col_idx_BRAM_ena         = wr_q[0];
  assign H_col_idx_BRAM_addra       = col_addr_q;
  assign H_col_idx_BRAM_load_done   = done_q[0];
  assign H_value_BRAM_din           = val_din_q;
  assign H_value_BRAM_ena           = wr_q[1];
  assign H_value_BRAM_addra         = val_addr_q;
  assign H_value_BRAM_load_done     = done_q[1];
  assign H_node_info_BRAM_din       = ni_din_q;
  assign H_node_info_BRAM_ena       = wr_q[2];
  assign H_node_info_BRAM_addra     = ni_addr_q;
  assign H_node_info_BRAM_load_done = done_q[2];
  assign Weight_BRAM_din            = w_din_q;
  assign Weight_BRAM_ena            = wr_q[3];
  assign Weight_BRAM_addra          = w_addr_q;
  assign Weight_BRAM_load_done      = done_q[3];
  assign a_BRAM_din                 = a_din_q;
  assign a_BRAM_ena                 = wr_q[4];
  assign a_BRAM_addra               = a_addr_q;
  assign a_BRAM_load_done           = done_q[4];

endmodule

// File: tb/tb_gat_bram_loader.sv
// Testbench for gat_bram_loader: directed frames plus randomized data and
// stalls, checked against a frame-level model of expected BRAM writes,
// load_done timing and error flag.
module tb_gat_bram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [10:0] c_din;  logic c_ena;  logic [7:0] c_addr;  logic c_done;
  logic [7:0]  v_din;  logic v_ena;  logic [7:0] v_addr;  logic v_done;
  logic [14:0] ni_din; logic ni_ena; logic [3:0] ni_addr; logic ni_done;
  logic [7:0]  w_din;  logic w_ena;  logic [7:0] w_addr;  logic w_done;
  logic [7:0]  a_din;  logic a_ena;  logic [4:0] a_addr;  logic a_done;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  gat_bram_loader dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .H_col_idx_BRAM_din(c_din), .H_col_idx_BRAM_ena(c_ena),
    .H_col_idx_BRAM_addra(c_addr), .H_col_idx_BRAM_load_done(c_done),
    .H_value_BRAM_din(v_din), .H_value_BRAM_ena(v_ena),
    .H_value_BRAM_addra(v_addr), .H_value_BRAM_load_done(v_done),
    .H_node_info_BRAM_din(ni_din), .H_node_info_BRAM_ena(ni_ena),
    .H_node_info_BRAM_addra(ni_addr), .H_node_info_BRAM_load_done(ni_done),
    .Weight_BRAM_din(w_din), .Weight_BRAM_ena(w_ena),
    .Weight_BRAM_addra(w_addr), .Weight_BRAM_load_done(w_done),
    .a_BRAM_din(a_din), .a_BRAM_ena(a_ena),
    .a_BRAM_addra(a_addr), .a_BRAM_load_done(a_done),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int sec;
    int addr;
    int data;
    int cyc;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  wr_t         got[$];
  int          done_cyc[5];
  logic [31:0] prev_din[5];
  logic [31:0] prev_addr[5];
  bit          skip_hold = 1'b1;

  int          lens[5];
  int          hdr_idx[5];
  int          last_pos;
  logic [31:0] w_data[$];
  int          w_sec[$];
  int          w_ent[$];
  int          acc_cyc[$];

  function automatic int dep(input int s);
    case (s)
      0: return 242;
      1: return 242;
      2: return 13;
      3: return 256;
      default: return 32;
    endcase
  endfunction

  function automatic int wid(input int s);
    case (s)
      0: return 11;
      2: return 15;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle observation: records writes, load_done rise times, invariants.
  task automatic sample();
    logic [4:0]  ena_v;
    logic [4:0]  done_v;
    logic [31:0] din_v[5];
    logic [31:0] addr_v[5];
    bit          hold_ok;
    bit          sticky_ok;
    wr_t         w;
    ncyc++;
    ena_v  = {a_ena, w_ena, ni_ena, v_ena, c_ena};
    done_v = {a_done, w_done, ni_done, v_done, c_done};
    din_v[0] = 32'(c_din);   addr_v[0] = 32'(c_addr);
    din_v[1] = 32'(v_din);   addr_v[1] = 32'(v_addr);
    din_v[2] = 32'(ni_din);  addr_v[2] = 32'(ni_addr);
    din_v[3] = 32'(w_din);   addr_v[3] = 32'(w_addr);
    din_v[4] = 32'(a_din);   addr_v[4] = 32'(a_addr);
    chk("ena_onehot", 32'($countones(ena_v) <= 1), 32'd1);
    hold_ok = 1'b1;
    sticky_ok = 1'b1;
    for (int s = 0; s < 5; s++) begin
      if (ena_v[s] === 1'b1) begin
        w.sec = s; w.addr = int'(addr_v[s]); w.data = int'(din_v[s]); w.cyc = ncyc;
        got.push_back(w);
      end else if (!skip_hold && (din_v[s] !== prev_din[s] || addr_v[s] !== prev_addr[s])) begin
        hold_ok = 1'b0;
      end
      if (done_cyc[s] >= 0 && done_v[s] !== 1'b1) sticky_ok = 1'b0;
      if (done_v[s] === 1'b1 && done_cyc[s] < 0) done_cyc[s] = ncyc;
      prev_din[s] = din_v[s];
      prev_addr[s] = addr_v[s];
    end
    chk("din_addr_hold", 32'(hold_ok), 32'd1);
    chk("done_sticky", 32'(sticky_ok), 32'd1);
    skip_hold = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    rst = 1'b1;
    for (int s = 0; s < 5; s++) done_cyc[s] = -1;
    skip_hold = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    chk("rst_ena", 32'({a_ena, w_ena, ni_ena, v_ena, c_ena}), 32'd0);
    chk("rst_done", 32'({a_done, w_done, ni_done, v_done, c_done}), 32'd0);
    chk("rst_din", 32'(c_din) | 32'(v_din) | 32'(ni_din) | 32'(w_din) | 32'(a_din), 32'd0);
    chk("rst_addr", 32'(c_addr) | 32'(v_addr) | 32'(ni_addr) | 32'(w_addr) | 32'(a_addr), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
  endtask

  // Builds the word list from lens[]; last_pos defaults to the final word.
  task automatic build_frame(input bit addr_data);
    w_data.delete(); w_sec.delete(); w_ent.delete(); acc_cyc.delete();
    for (int s = 0; s < 5; s++) begin
      hdr_idx[s] = w_data.size();
      w_data.push_back({16'($urandom), 16'(lens[s])});
      w_sec.push_back(s); w_ent.push_back(-1); acc_cyc.push_back(-1);
      for (int e = 0; e < lens[s]; e++) begin
        w_data.push_back(addr_data ? 32'(e) : $urandom());
        w_sec.push_back(s); w_ent.push_back(e); acc_cyc.push_back(-1);
      end
    end
    last_pos = w_data.size() - 1;
  endtask

  task automatic send_words(input int from, input int to, input bit gaps, input int fend);
    for (int k = from; k <= to; k++) begin
      if (gaps) begin
        for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
          s_valid = 1'b0;
          s_last = 1'b0;
          tick();
        end
      end
      s_valid = 1'b1;
      s_data = w_data[k];
      s_last = (k == last_pos);
      chk("s_ready_open", 32'(s_ready), 32'd1);
      acc_cyc[k] = (s_ready === 1'b1) ? ncyc : -100;
      tick();
      if (k < fend) chk("busy_mid", 32'(busy_o), 32'd1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic run_frame(input bit gaps);
    wr_t ex[$];
    wr_t e;
    int  total;
    int  fend;
    int  lw;
    int  exp_cyc;
    bit  exp_err;
    total = w_data.size();
    fend = (last_pos >= 0 && last_pos < total - 1) ? last_pos : total - 1;
    got.delete();
    send_words(0, fend, gaps, fend);
    repeat (4) tick();
    exp_err = (last_pos != total - 1);
    for (int k = 0; k <= fend; k++) begin
      if (w_ent[k] < 0) begin
        if (lens[w_sec[k]] > dep(w_sec[k])) exp_err = 1'b1;
      end else if (w_ent[k] < dep(w_sec[k])) begin
        e.sec = w_sec[k];
        e.addr = w_ent[k];
        e.data = int'(w_data[k] & ((32'd1 << wid(w_sec[k])) - 32'd1));
        e.cyc = acc_cyc[k] + 1;
        ex.push_back(e);
      end
    end
    chk("n_writes", 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < got.size() && i < ex.size(); i++) begin
      chk($sformatf("wr%0d_sec", i), got[i].sec, ex[i].sec);
      chk($sformatf("wr%0d_addr", i), got[i].addr, ex[i].addr);
      chk($sformatf("wr%0d_data", i), got[i].data, ex[i].data);
      chk($sformatf("wr%0d_cycle", i), got[i].cyc, ex[i].cyc);
    end
    chk("err_o", 32'(err_o), 32'(exp_err));
    for (int s = 0; s < 5; s++) begin
      lw = hdr_idx[s] + lens[s];
      exp_cyc = (lw <= fend) ? acc_cyc[lw] + ((lens[s] == 0) ? 1 : 2) : -1;
      chk($sformatf("done%0d_cycle", s), done_cyc[s], exp_cyc);
    end
    chk("s_ready_done", 32'(s_ready), 32'd0);
    chk("busy_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 5; s++) done_cyc[s] = -1;
    do_reset();

    // Nominal frame, entries equal to addresses, no stalls.
    lens = '{4, 4, 2, 3, 2};
    build_frame(1'b1);
    run_frame(1'b0);

    // Empty Weight section.
    do_reset();
    lens = '{4, 4, 2, 0, 2};
    build_frame(1'b0);
    run_frame(1'b0);

    // a section overflow: 40 entries into a 32-deep BRAM.
    do_reset();
    lens = '{4, 4, 2, 3, 40};
    build_frame(1'b0);
    run_frame(1'b0);

    // Early s_last on entry 1 of H_value.
    do_reset();
    lens = '{4, 4, 2, 3, 2};
    build_frame(1'b0);
    last_pos = hdr_idx[1] + 2;
    run_frame(1'b0);

    // Nominal frame with random valid gaps.
    do_reset();
    lens = '{4, 4, 2, 3, 2};
    build_frame(1'b1);
    run_frame(1'b1);

    // Final word without s_last.
    do_reset();
    lens = '{4, 4, 2, 3, 2};
    build_frame(1'b0);
    last_pos = -1;
    run_frame(1'b0);

    // Reset in the middle of the Weight section, then a clean frame.
    do_reset();
    lens = '{4, 4, 2, 3, 2};
    build_frame(1'b0);
    send_words(0, hdr_idx[3] + 1, 1'b0, w_data.size() - 1);
    do_reset();
    build_frame(1'b0);
    run_frame(1'b0);

    // Random section lengths, data and stalls.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int s = 0; s < 5; s++) lens[s] = int'($urandom_range(0, 15));
      build_frame(1'b0);
      run_frame(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
